timer_apb_slave: RTL and testbench
==================================

// Module: timer_apb_slave
// PURPOSE
//   APB responder for the timer: decodes the register map (TCR, TDR0/1, TCMP0/1, TIER, TISR, THCSR),
//   holds the control/status registers and the 64-bit up-counter with prescaler, raises tim_int on compare.
//   Sits between the system APB fabric and the interrupt controller. It is the slave end of the
//   write/read bus-functional tasks used by the timer bench.
// PARAMETERS
//   ADDR_W   12   APB address width; only [11:0] decoded
//   DIV_MAX  8    largest legal TCR.div_val; larger values are rejected
// PORTS
//   sys_clk      in   1   single clock, all state rising-edge
//   sys_rst      in   1   asynchronous, active-high reset
//   tim_psel     in   1   APB select
//   tim_penable  in   1   APB enable (access phase)
//   tim_pwrite   in   1   1=write, 0=read
//   tim_paddr    in   12  byte address; offsets 0x00..0x1C, word aligned
//   tim_pwdata   in   32  write data
//   tim_pstrb    in   4   byte strobes for writes
//   tim_prdata   out  32  read data, valid when tim_pready=1
//   tim_pready   out  1   transfer complete
//   tim_pslverr  out  1   error, valid with tim_pready
//   dbg_mode     in   1   debug halt qualifier
//   tim_int      out  1   level interrupt = TISR.int_st & TIER.int_en
// BEHAVIOUR
//   Reset: all outputs 0; TCR=0x0000_0100, TDR0/1=0, TCMP0/1=0xFFFF_FFFF, TIER/TISR/THCSR=0.
//   APB FSM IDLE->SETUP(psel&!penable)->ACCESS: first ACCESS cycle pready=0, second pready=1
//     (one fixed wait state); register update and prdata/pslverr sampled in pready cycle; back to IDLE.
//     psel dropped mid-transfer -> IDLE, no update. Reset mid-transfer aborts it.
//   Writes honour pstrb per byte; reserved bits read 0. Unmapped offset: read 0, write dropped, pslverr=0.
//   TCR: [0] timer_en, [1] div_en, [11:8] div_val, rest RO 0.
//     Write with new div_val>DIV_MAX -> whole write dropped, pslverr=1.
//     Write changing div_en/div_val while current timer_en=1 -> dropped, pslverr=1.
//     e.g. 0xFFFF_FFFF rejected; 0x5555_5555 from reset-like state reads back 0x0000_0501.
//   Counter {TDR1,TDR0}: counts when timer_en & !halted. div_en=0 or div_val=0: +1 per cycle;
//     else +1 every 2^div_val cycles via internal prescaler. Wraps 0xFFFF..FF -> 0 silently.
//     timer_en 1->0 clears TDR0, TDR1 and prescaler in the same cycle.
//     SW write to TDR0/TDR1 wins over increment in the same cycle; prescaler restarts.
//   TISR[0] int_st: set the cycle {TDR1,TDR0}=={TCMP1,TCMP0} (evaluated on updated counter value);
//     W1C; set wins over simultaneous clear. TIER[0] int_en masks tim_int only, not int_st.
//   THCSR: [0] halt_req RW, [1] halt_ack RO = halt_req & dbg_mode. Halted: counter and prescaler
//     frozen, registers still accessible.
// STRUCTURE
//   Package timer_pkg: register offsets, field bit positions, reset values, DIV_MAX, APB state enum.
//   Sub-module timer_cnt: prescaler + 64-bit counter + compare, load/clear/halt inputs.
//   Top holds APB FSM, decode, register file, error checks.
// TESTING
//   Reset, read all 8 offsets -> TCR 0x100, TCMP0/1 0xFFFF_FFFF, others 0; pready after 1 wait state.
//   Write TCR 0x0 then 0xFFFF_FFFF -> second gets pslverr=1, TCR reads 0x0; then 0x5555_5555 -> reads 0x501.
//   timer_en=1 then write div_val=2 -> pslverr=1, TCR unchanged; write timer_en=0 -> TDR0/1 read 0.
//   TCMP0=0x10, TCMP1=0, TIER=1, TCR=0x1 -> tim_int rises cycle TDR0 hits 0x10; W1C TISR=1 -> tim_int 0.
//   div_en=1, div_val=3, start -> TDR0 increments every 8 cycles; TDR0 preload 0xFFFF_FFFF -> carry to TDR1.
//   halt_req=1, dbg_mode=1 -> halt_ack=1, TDR frozen; dbg_mode=0 -> resumes; pstrb=4'b0001 -> byte-only write.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer: register map, field positions,
// reset values and the APB responder state type.
package timer_pkg;

   localparam logic [11:0] OFF_TCR   = 12'h000;
   localparam logic [11:0] OFF_TDR0  = 12'h004;
   localparam logic [11:0] OFF_TDR1  = 12'h008;
   localparam logic [11:0] OFF_TCMP0 = 12'h00C;
   localparam logic [11:0] OFF_TCMP1 = 12'h010;
   localparam logic [11:0] OFF_TIER  = 12'h014;
   localparam logic [11:0] OFF_TISR  = 12'h018;
   localparam logic [11:0] OFF_THCSR = 12'h01C;

   localparam int unsigned TCR_EN_BIT     = 0;
   localparam int unsigned TCR_DIV_EN_BIT = 1;
   localparam int unsigned TCR_DIV_LSB    = 8;

   localparam logic [31:0] TCR_RST  = 32'h0000_0100;
   localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

   localparam int unsigned DIV_MAX_DEF = 8;

   // ACCESS is the first access-phase cycle (wait state), READY the completing one
   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_ACCESS = 2'd1,
      APB_READY  = 2'd2
   } apb_state_e;

   // Byte-strobed merge of write data into an existing word
   function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_w;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/timer_apb_slave_if.sv
// APB bus bundle between the system fabric (master) and the timer (slave).
interface timer_apb_slave_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              tim_psel;
   logic              tim_penable;
   logic              tim_pwrite;
   logic [ADDR_W-1:0] tim_paddr;
   logic [31:0]       tim_pwdata;
   logic [3:0]        tim_pstrb;
   logic [31:0]       tim_prdata;
   logic              tim_pready;
   logic              tim_pslverr;

   modport master (
      output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
      input  tim_prdata, tim_pready, tim_pslverr
   );

   modport slave (
      input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
      output tim_prdata, tim_pready, tim_pslverr
   );
endinterface

// File: rtl/timer_cnt.sv
// 64-bit up-counter with power-of-two prescaler and compare.
// Priority: clear, then software load, then counting.
module timer_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        cnt_en,
   input  logic        halt,
   input  logic        div_en,
   input  logic [3:0]  div_val,
   input  logic        clr,
   input  logic        ld_lo,
   input  logic        ld_hi,
   input  logic [31:0] ld_data,
   input  logic [63:0] cmp,
   output logic [63:0] cnt,
   output logic        match
);
   logic [63:0] cnt_q, cnt_d;
   logic [15:0] pre_q, pre_d;
   logic [15:0] pre_last;

   assign pre_last = (16'd1 << div_val) - 16'd1;
   assign cnt      = cnt_q;
   // compare against the value the counter takes this edge
   assign match    = (cnt_d == cmp);

   // Next counter / prescaler value
   always_comb begin
      cnt_d = cnt_q;
      pre_d = pre_q;
      if (clr) begin
         cnt_d = '0;
         pre_d = '0;
      end else if (ld_lo || ld_hi) begin
         if (ld_lo) cnt_d[31:0]  = ld_data;
         if (ld_hi) cnt_d[63:32] = ld_data;
         pre_d = '0;
      end else if (cnt_en && !halt) begin
         if (!div_en || div_val == 4'd0) begin
            cnt_d = cnt_q + 64'd1;
            pre_d = '0;
         end else if (pre_q == pre_last) begin
            cnt_d = cnt_q + 64'd1;
            pre_d = '0;
         end else begin
            pre_d = pre_q + 16'd1;
         end
      end
   end

   // Counter and prescaler state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         pre_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         pre_q <= pre_d;
      end
   end
endmodule

// File: rtl/timer_apb_slave.sv
// APB responder for the timer: one-wait-state APB FSM, register decode,
// control/status registers and TCR write checks around timer_cnt.
module timer_apb_slave
   import timer_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DIV_MAX = DIV_MAX_DEF
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   timer_apb_slave_if.slave apb,
   input  logic             dbg_mode,
   output logic             tim_int
);
   apb_state_e  state_q, state_d;
   logic        timer_en_q, timer_en_d;
   logic        div_en_q, div_en_d;
   logic [3:0]  div_val_q, div_val_d;
   logic [63:0] cmp_q, cmp_d;
   logic        int_en_q, int_en_d;
   logic        int_st_q, int_st_d;
   logic        halt_req_q, halt_req_d;

   logic        xfer, wr, halt_ack, tcr_err, clr, ld_lo, ld_hi, w1c, match;
   logic        sel_tcr, sel_tdr0, sel_tdr1, sel_tcmp0, sel_tcmp1, sel_tier, sel_tisr, sel_thcsr;
   logic [31:0] tcr_word, tcr_new, rd_word, ld_data;
   logic [63:0] cnt;

   assign xfer     = (state_q == APB_READY) && apb.tim_psel && apb.tim_penable;
   assign wr       = xfer && apb.tim_pwrite;
   assign halt_ack = halt_req_q && dbg_mode;
   assign tcr_word = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
   assign tcr_new  = strb_merge(tcr_word, apb.tim_pwdata, apb.tim_pstrb);

   assign sel_tcr   = (apb.tim_paddr == ADDR_W'(OFF_TCR));
   assign sel_tdr0  = (apb.tim_paddr == ADDR_W'(OFF_TDR0));
   assign sel_tdr1  = (apb.tim_paddr == ADDR_W'(OFF_TDR1));
   assign sel_tcmp0 = (apb.tim_paddr == ADDR_W'(OFF_TCMP0));
   assign sel_tcmp1 = (apb.tim_paddr == ADDR_W'(OFF_TCMP1));
   assign sel_tier  = (apb.tim_paddr == ADDR_W'(OFF_TIER));
   assign sel_tisr  = (apb.tim_paddr == ADDR_W'(OFF_TISR));
   assign sel_thcsr = (apb.tim_paddr == ADDR_W'(OFF_THCSR));

   // Reject out-of-range divider, or any divider change while running
   assign tcr_err = wr && sel_tcr &&
                    ((32'(tcr_new[TCR_DIV_LSB +: 4]) > DIV_MAX) ||
                     (timer_en_q && ((tcr_new[TCR_DIV_EN_BIT] != div_en_q) ||
                                     (tcr_new[TCR_DIV_LSB +: 4] != div_val_q))));

   assign apb.tim_pready  = (state_q == APB_READY);
   assign apb.tim_prdata  = (xfer && !apb.tim_pwrite) ? rd_word : '0;
   assign apb.tim_pslverr = tcr_err;
   assign tim_int         = int_st_q && int_en_q;

   // APB FSM next state: setup seen in IDLE, one wait cycle, then completion
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         APB_IDLE:   if (apb.tim_psel && !apb.tim_penable) state_d = APB_ACCESS;
         APB_ACCESS: state_d = (apb.tim_psel && apb.tim_penable) ? APB_READY : APB_IDLE;
         APB_READY:  state_d = APB_IDLE;
         default:    state_d = APB_IDLE;
      endcase
   end

   // Read data mux; unmapped offsets read zero
   always_comb begin
      rd_word = '0;
      if (sel_tcr)   rd_word = tcr_word;
      if (sel_tdr0)  rd_word = cnt[31:0];
      if (sel_tdr1)  rd_word = cnt[63:32];
      if (sel_tcmp0) rd_word = cmp_q[31:0];
      if (sel_tcmp1) rd_word = cmp_q[63:32];
      if (sel_tier)  rd_word = {31'd0, int_en_q};
      if (sel_tisr)  rd_word = {31'd0, int_st_q};
      if (sel_thcsr) rd_word = {30'd0, halt_ack, halt_req_q};
   end

   // Register write decode and counter control
   always_comb begin
      timer_en_d = timer_en_q;
      div_en_d   = div_en_q;
      div_val_d  = div_val_q;
      cmp_d      = cmp_q;
      int_en_d   = int_en_q;
      halt_req_d = halt_req_q;
      clr        = 1'b0;
      ld_lo      = wr && sel_tdr0;
      ld_hi      = wr && sel_tdr1;
      ld_data    = strb_merge(sel_tdr1 ? cnt[63:32] : cnt[31:0], apb.tim_pwdata, apb.tim_pstrb);
      w1c        = wr && sel_tisr && apb.tim_pstrb[0] && apb.tim_pwdata[0];
      if (wr) begin
         if (sel_tcr && !tcr_err) begin
            timer_en_d = tcr_new[TCR_EN_BIT];
            div_en_d   = tcr_new[TCR_DIV_EN_BIT];
            div_val_d  = tcr_new[TCR_DIV_LSB +: 4];
            clr        = timer_en_q && !tcr_new[TCR_EN_BIT];
         end
         if (sel_tcmp0) cmp_d[31:0]  = strb_merge(cmp_q[31:0], apb.tim_pwdata, apb.tim_pstrb);
         if (sel_tcmp1) cmp_d[63:32] = strb_merge(cmp_q[63:32], apb.tim_pwdata, apb.tim_pstrb);
         if (sel_tier && apb.tim_pstrb[0])  int_en_d   = apb.tim_pwdata[0];
         if (sel_thcsr && apb.tim_pstrb[0]) halt_req_d = apb.tim_pwdata[0];
      end
   end

   // Status: a compare hit outranks a simultaneous W1C
   always_comb begin
      int_st_d = (int_st_q && !w1c) || match;
   end

   timer_cnt u_cnt (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .cnt_en  (timer_en_q),
      .halt    (halt_ack),
      .div_en  (div_en_q),
      .div_val (div_val_q),
      .clr     (clr),
      .ld_lo   (ld_lo),
      .ld_hi   (ld_hi),
      .ld_data (ld_data),
      .cmp     (cmp_d),
      .cnt     (cnt),
      .match   (match)
   );

   // State and register flops
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= APB_IDLE;
         timer_en_q <= TCR_RST[TCR_EN_BIT];
         div_en_q   <= TCR_RST[TCR_DIV_EN_BIT];
         div_val_q  <= TCR_RST[TCR_DIV_LSB +: 4];
         cmp_q      <= {TCMP_RST, TCMP_RST};
         int_en_q   <= 1'b0;
         int_st_q   <= 1'b0;
         halt_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_en_q <= timer_en_d;
         div_en_q   <= div_en_d;
         div_val_q  <= div_val_d;
         cmp_q      <= cmp_d;
         int_en_q   <= int_en_d;
         int_st_q   <= int_st_d;
         halt_req_q <= halt_req_d;
      end
   end
endmodule

// File: tb/tb_timer_apb_slave.sv
// Scoreboard bench for timer_apb_slave: directed scenarios then random APB
// traffic, checked against a cycle-level behavioural model of the timer.
module tb_timer_apb_slave;
   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;
   logic dbg_mode = 1'b0;
   logic tim_int;

   timer_apb_slave_if #(.ADDR_W(12)) apb ();

   timer_apb_slave #(.ADDR_W(12), .DIV_MAX(8)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .apb      (apb.slave),
      .dbg_mode (dbg_mode),
      .tim_int  (tim_int)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic [11:0] addr;
      logic        wr;
   } exp_t;
   exp_t exp_q[$];
   logic exp_ready = 1'b0;

   // ---------------- behavioural model ----------------
   logic        m_en, m_div_en, m_int_en, m_int_st, m_halt;
   logic [3:0]  m_div_val;
   logic [63:0] m_base, m_run, m_cmp;
   // completing transfer presented to the model at the next edge
   logic        c_valid = 1'b0, c_write = 1'b0;
   logic [11:0] c_addr = '0;
   logic [31:0] c_data = '0;
   logic [3:0]  c_strb = '0;

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~mask) | (d & mask);
   endfunction

   // counter = value at last load + elapsed counting cycles / 2^div
   function automatic logic [63:0] m_cnt();
      int sh;
      sh = (m_div_en && m_div_val != 4'd0) ? int'(m_div_val) : 0;
      return m_base + (m_run >> sh);
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      logic [63:0] c;
      c = m_cnt();
      case (a)
         12'h000: return {20'd0, m_div_val, 6'd0, m_div_en, m_en};
         12'h004: return c[31:0];
         12'h008: return c[63:32];
         12'h00C: return m_cmp[31:0];
         12'h010: return m_cmp[63:32];
         12'h014: return {31'd0, m_int_en};
         12'h018: return {31'd0, m_int_st};
         12'h01C: return {30'd0, m_halt && dbg_mode, m_halt};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_reject(input logic [31:0] d, input logic [3:0] s);
      logic [31:0] n;
      n = bmerge(m_read(12'h000), d, s);
      return (n[11:8] > 4'd8) || (m_en && (n[1] != m_div_en || n[11:8] != m_div_val));
   endfunction

   task automatic model_reset();
      m_en = 1'b0; m_div_en = 1'b0; m_div_val = 4'd1;
      m_base = '0; m_run = '0; m_cmp = '1;
      m_int_en = 1'b0; m_int_st = 1'b0; m_halt = 1'b0;
   endtask

   task automatic model_step();
      logic [63:0] old;
      logic [31:0] n;
      logic        tick, loaded, w1c;
      old    = m_cnt();
      tick   = m_en && !(m_halt && dbg_mode);
      loaded = 1'b0;
      w1c    = 1'b0;
      if (c_valid && c_write) begin
         case (c_addr)
            12'h000: if (!m_reject(c_data, c_strb)) begin
               n = bmerge(m_read(12'h000), c_data, c_strb);
               if (m_en && !n[0]) begin m_base = '0; m_run = '0; loaded = 1'b1; end
               m_en = n[0]; m_div_en = n[1]; m_div_val = n[11:8];
            end
            12'h004: begin m_base = {old[63:32], bmerge(old[31:0], c_data, c_strb)}; m_run = '0; loaded = 1'b1; end
            12'h008: begin m_base = {bmerge(old[63:32], c_data, c_strb), old[31:0]}; m_run = '0; loaded = 1'b1; end
            12'h00C: m_cmp[31:0]  = bmerge(m_cmp[31:0], c_data, c_strb);
            12'h010: m_cmp[63:32] = bmerge(m_cmp[63:32], c_data, c_strb);
            12'h014: if (c_strb[0]) m_int_en = c_data[0];
            12'h018: w1c = c_strb[0] && c_data[0];
            12'h01C: if (c_strb[0]) m_halt = c_data[0];
            default: ;
         endcase
      end
      if (!loaded && tick) m_run = m_run + 64'd1;
      m_int_st = (m_int_st && !w1c) || (m_cnt() == m_cmp);
   endtask

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) model_reset();
      else         model_step();
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: handshake timing, interrupt level, and scoreboard pop on pready
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         chk("pready", {31'd0, apb.tim_pready}, {31'd0, exp_ready});
         chk("tim_int", {31'd0, tim_int}, {31'd0, m_int_st && m_int_en});
         if (apb.tim_pready && exp_ready) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (e.wr) chk($sformatf("wr_pslverr@%h", e.addr), {31'd0, apb.tim_pslverr}, {31'd0, e.err});
               else begin
                  chk($sformatf("rdata@%h", e.addr), apb.tim_prdata, e.data);
                  chk($sformatf("rd_pslverr@%h", e.addr), {31'd0, apb.tim_pslverr}, 32'd0);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called at posedge+1 with the DUT idle; returns at posedge+1 with the bus idle.
   task automatic apb_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic abort);
      exp_t e;
      apb.tim_psel = 1'b1; apb.tim_penable = 1'b0; apb.tim_pwrite = w;
      apb.tim_paddr = a; apb.tim_pwdata = d; apb.tim_pstrb = s;
      @(posedge sys_clk) #1;
      if (abort) begin
         apb.tim_psel = 1'b0;
         @(posedge sys_clk) #1;
         return;
      end
      apb.tim_penable = 1'b1;
      @(posedge sys_clk) #1;
      e.data = w ? 32'd0 : m_read(a);
      e.err  = w && (a == 12'h000) && m_reject(d, s);
      e.addr = a;
      e.wr   = w;
      exp_q.push_back(e);
      exp_ready = 1'b1;
      c_valid = 1'b1; c_write = w; c_addr = a; c_data = d; c_strb = s;
      @(posedge sys_clk) #1;
      exp_ready = 1'b0;
      c_valid = 1'b0;
      apb.tim_psel = 1'b0; apb.tim_penable = 1'b0;
   endtask

   task automatic wr32(input logic [11:0] a, input logic [31:0] d);
      apb_xfer(1'b1, a, d, 4'hF, 1'b0);
   endtask

   task automatic rd32(input logic [11:0] a);
      apb_xfer(1'b0, a, 32'd0, 4'h0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      apb.tim_psel = 1'b0; apb.tim_penable = 1'b0; apb.tim_pwrite = 1'b0;
      apb.tim_paddr = '0; apb.tim_pwdata = '0; apb.tim_pstrb = '0;
      #2 sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_pready", {31'd0, apb.tim_pready}, 32'd0);
      chk("rst_pslverr", {31'd0, apb.tim_pslverr}, 32'd0);
      chk("rst_prdata", apb.tim_prdata, 32'd0);
      chk("rst_tim_int", {31'd0, tim_int}, 32'd0);
      @(posedge sys_clk) #1 sys_rst = 1'b0;
      idle(1);

      // reset values of the whole map plus unmapped/unaligned offsets
      for (int unsigned i = 0; i < 8; i++) rd32(12'(i * 4));
      rd32(12'h020); rd32(12'h002);
      apb_xfer(1'b1, 12'h040, 32'hDEAD_BEEF, 4'hF, 1'b0);

      // TCR divider range check and read-back of masked fields
      wr32(12'h000, 32'h0);
      wr32(12'h000, 32'hFFFF_FFFF);
      rd32(12'h000);
      wr32(12'h000, 32'h5555_5555);
      rd32(12'h000);
      idle(4); rd32(12'h004);
      // divider change while running is refused; disabling clears the count
      wr32(12'h000, 32'h0000_0201);
      rd32(12'h000);
      wr32(12'h000, 32'h0);
      rd32(12'h004); rd32(12'h008);

      // compare interrupt and W1C
      wr32(12'h00C, 32'h10); wr32(12'h010, 32'h0); wr32(12'h014, 32'h1);
      wr32(12'h000, 32'h1);
      idle(30);
      rd32(12'h018);
      wr32(12'h018, 32'h1);
      rd32(12'h018);
      wr32(12'h000, 32'h0);

      // prescaler /8 and carry into TDR1
      wr32(12'h000, 32'h0000_0303);
      for (int i = 0; i < 6; i++) begin idle(3 + i); rd32(12'h004); end
      wr32(12'h000, 32'h0);
      wr32(12'h004, 32'hFFFF_FFF8);
      wr32(12'h000, 32'h1);
      idle(12);
      rd32(12'h004); rd32(12'h008);

      // halt qualified by dbg_mode, then resume
      wr32(12'h01C, 32'h1);
      rd32(12'h01C);
      dbg_mode = 1'b1;
      rd32(12'h01C); rd32(12'h004); idle(10); rd32(12'h004);
      dbg_mode = 1'b0;
      idle(5); rd32(12'h004); rd32(12'h01C);
      wr32(12'h01C, 32'h0);

      // byte strobe write and an aborted transfer
      apb_xfer(1'b1, 12'h00C, 32'hAABB_CCDD, 4'b0001, 1'b0);
      rd32(12'h00C);
      apb_xfer(1'b1, 12'h010, 32'h1234_5678, 4'hF, 1'b1);
      rd32(12'h010);
      wr32(12'h000, 32'h0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic [11:0] a;
         logic [31:0] d;
         logic [63:0] c;
         logic [3:0]  s;
         int unsigned r;
         r = $urandom_range(0, 15);
         if (r == 0) begin
            a = ($urandom_range(0, 1) == 0) ? 12'h024 : 12'h003;
         end else begin
            a = 12'($urandom_range(0, 7) * 4);
         end
         d = $urandom;
         s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         c = m_cnt();
         if (a == 12'h000) begin
            case ($urandom_range(0, 7))
               0: d = 32'h0;
               1: d = 32'h1;
               2: d = 32'h101;
               3: d = 32'h303;
               4: d = 32'h803;
               5: d = 32'h903;
               6: d = 32'h203;
               default: ;
            endcase
         end else if (a == 12'h00C) begin
            d = c[31:0] + 32'($urandom_range(0, 40));
         end else if (a == 12'h010) begin
            d = c[63:32];
         end else if (a == 12'h004 && $urandom_range(0, 1) == 0) begin
            d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 9) == 0) dbg_mode = ~dbg_mode;
         apb_xfer(logic'($urandom_range(0, 1)), a, d, s, logic'($urandom_range(0, 19) == 0));
         idle($urandom_range(0, 5));
      end

      idle(5);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
